// File: rtl/quiz_buzz_arbiter_if.sv
// Player-facing bus of the quiz buzzer arbiter: round control, buzzers, answers,
// answer-key write port and the per-player results.
interface quiz_buzz_arbiter_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int TIME_W      = 26,
    parameter int OPT_W       = 4,
    parameter int QSEL_W      = 3
);
    localparam int RANK_W = $clog2(NUM_PLAYERS + 1);

    logic                          tic;
    logic                          start;
    logic                          game_over;
    logic [QSEL_W-1:0]             question_sel;
    logic [NUM_PLAYERS-1:0]        buzz_n;
    logic [NUM_PLAYERS*OPT_W-1:0]  answer;
    logic                          key_we;
    logic [QSEL_W-1:0]             key_addr;
    logic [OPT_W-1:0]              key_data;

    logic                          round_done;
    logic                          armed;
    logic [NUM_PLAYERS-1:0]        pressed;
    logic [NUM_PLAYERS-1:0]        correct;
    logic [NUM_PLAYERS*TIME_W-1:0] player_time;
    logic [NUM_PLAYERS*RANK_W-1:0] player_rank;
    logic [NUM_PLAYERS-1:0]        disq;

    modport master (
        output tic, start, game_over, question_sel, buzz_n, answer,
               key_we, key_addr, key_data,
        input  round_done, armed, pressed, correct, player_time, player_rank, disq
    );

    modport slave (
        input  tic, start, game_over, question_sel, buzz_n, answer,
               key_we, key_addr, key_data,
        output round_done, armed, pressed, correct, player_time, player_rank, disq
    );
endinterface

// File: rtl/quiz_buzz_arbiter.sv
// N-player buzzer arbiter: times buzzes in ms tics, dense-ranks arrival order and scores
// answers against a programmable key. Define QUIZ_FALSE_START_EN to disqualify early buzzers.
module quiz_buzz_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int TIME_W      = 26,
    parameter int OPT_W       = 4,
    parameter int QSEL_W      = 3,
    parameter int TIMEOUT_MS  = 10000
) (
    input  logic               clock,
    input  logic               reset,
    quiz_buzz_arbiter_if.slave bus
);
    localparam int RANK_W    = $clog2(NUM_PLAYERS + 1);
    localparam int KEY_DEPTH = 1 << QSEL_W;
    localparam logic [TIME_W-1:0] TIMEOUT_VAL = TIME_W'(TIMEOUT_MS);
    localparam logic [TIME_W-1:0] TIME_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [TIME_W-1:0]      elapsed_q, elapsed_d;
    logic [RANK_W-1:0]      next_rank_q, next_rank_d;
    logic [OPT_W-1:0]       key_q [KEY_DEPTH];
    logic [OPT_W-1:0]       key_d [KEY_DEPTH];
    logic [OPT_W-1:0]       cur_key_q, cur_key_d;
    logic [NUM_PLAYERS-1:0] pressed_q, pressed_d;
    logic [NUM_PLAYERS-1:0] correct_q, correct_d;
    logic [NUM_PLAYERS-1:0] disq_q, disq_d;
    logic [TIME_W-1:0]      time_q [NUM_PLAYERS];
    logic [TIME_W-1:0]      time_d [NUM_PLAYERS];
    logic [RANK_W-1:0]      rank_q [NUM_PLAYERS];
    logic [RANK_W-1:0]      rank_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] capture;
`ifdef QUIZ_FALSE_START_EN
    logic                   first_q, first_d;
`endif

    always_comb begin
        state_d     = state_q;
        elapsed_d   = elapsed_q;
        next_rank_d = next_rank_q;
        key_d       = key_q;
        cur_key_d   = cur_key_q;
        pressed_d   = pressed_q;
        correct_d   = correct_q;
        disq_d      = disq_q;
        time_d      = time_q;
        rank_d      = rank_q;
        capture     = '0;
`ifdef QUIZ_FALSE_START_EN
        first_d     = 1'b0;
`endif

        // The active key is latched from the pre-write contents, so a write never touches a live round
        if (bus.key_we) begin
            key_d[bus.key_addr] = bus.key_data;
        end

        if (bus.game_over || bus.start) begin
            state_d     = bus.game_over ? IDLE : ARMED;
            elapsed_d   = '0;
            next_rank_d = RANK_W'(1);
            pressed_d   = '0;
            correct_d   = '0;
            disq_d      = '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                time_d[i] = '0;
                rank_d[i] = '0;
            end
            if (!bus.game_over) begin
                cur_key_d = key_q[bus.question_sel];
`ifdef QUIZ_FALSE_START_EN
                first_d   = 1'b1;
                disq_d    = ~bus.buzz_n;
                pressed_d = ~bus.buzz_n;
`endif
            end
        end else if (state_q == ARMED) begin
            if (bus.tic && (elapsed_q != TIME_MAX)) begin
                elapsed_d = elapsed_q + TIME_W'(1);
            end
            capture = ~bus.buzz_n & ~pressed_q;
`ifdef QUIZ_FALSE_START_EN
            // Buzzing on the first armed cycle is still a false start: no rank is consumed
            if (first_q) begin
                disq_d    = disq_q | capture;
                pressed_d = pressed_q | capture;
                capture   = '0;
            end
`endif
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (capture[i]) begin
                    pressed_d[i] = 1'b1;
                    time_d[i]    = elapsed_q;
                    rank_d[i]    = next_rank_q;
                    correct_d[i] = (bus.answer[i*OPT_W +: OPT_W] == cur_key_q) && (cur_key_q != '0);
                end
            end
            if (|capture) begin
                next_rank_d = next_rank_q + RANK_W'(1);
            end
            if (&pressed_d) begin
                state_d = DONE;
            end else if (elapsed_q >= TIMEOUT_VAL) begin
                state_d = DONE;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (!pressed_d[i]) begin
                        time_d[i] = TIMEOUT_VAL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            elapsed_q   <= '0;
            next_rank_q <= RANK_W'(1);
            cur_key_q   <= '0;
            pressed_q   <= '0;
            correct_q   <= '0;
            disq_q      <= '0;
            for (int q = 0; q < KEY_DEPTH; q++) begin
                key_q[q] <= OPT_W'(1) << (q % OPT_W);
            end
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                time_q[i] <= '0;
                rank_q[i] <= '0;
            end
`ifdef QUIZ_FALSE_START_EN
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            elapsed_q   <= elapsed_d;
            next_rank_q <= next_rank_d;
            cur_key_q   <= cur_key_d;
            pressed_q   <= pressed_d;
            correct_q   <= correct_d;
            disq_q      <= disq_d;
            key_q       <= key_d;
            time_q      <= time_d;
            rank_q      <= rank_d;
`ifdef QUIZ_FALSE_START_EN
            first_q     <= first_d;
`endif
        end
    end

    assign bus.round_done = (state_q == DONE);
    assign bus.armed      = (state_q == ARMED);
    assign bus.pressed    = pressed_q;
    assign bus.correct    = correct_q;
    assign bus.disq       = disq_q;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign bus.player_time[g*TIME_W +: TIME_W] = time_q[g];
        assign bus.player_rank[g*RANK_W +: RANK_W] = rank_q[g];
    end
endmodule

// File: tb/tb_quiz_buzz_arbiter.sv
// Scoreboard bench for quiz_buzz_arbiter: directed rounds push expected results,
// monitors compare them when round_done rises.
module tb_quiz_buzz_arbiter;
    localparam int NP   = 4;
    localparam int TW_A = 26;
    localparam int TW_B = 4;
    localparam int RW   = 3;

    typedef struct {
        string            name;
        logic [NP-1:0]    pressed;
        logic [NP-1:0]    correct;
        logic [NP-1:0]    disq;
        logic [NP*TW_A-1:0] times;
        logic [NP*RW-1:0] ranks;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic done_a_prev = 1'b0;
    logic done_b_prev = 1'b0;

    always #5 clock = ~clock;

    quiz_buzz_arbiter_if #(.NUM_PLAYERS(NP), .TIME_W(TW_A), .OPT_W(4), .QSEL_W(3)) ifa ();
    quiz_buzz_arbiter_if #(.NUM_PLAYERS(NP), .TIME_W(TW_B), .OPT_W(4), .QSEL_W(3)) ifb ();

    quiz_buzz_arbiter #(
        .NUM_PLAYERS(NP), .TIME_W(TW_A), .OPT_W(4), .QSEL_W(3), .TIMEOUT_MS(20)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (ifa)
    );

    quiz_buzz_arbiter #(
        .NUM_PLAYERS(NP), .TIME_W(TW_B), .OPT_W(4), .QSEL_W(3), .TIMEOUT_MS(14)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (ifb)
    );

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NP*TW_A-1:0] times_a(input int t3, input int t2, input int t1, input int t0);
        return {TW_A'(t3), TW_A'(t2), TW_A'(t1), TW_A'(t0)};
    endfunction

    function automatic logic [NP*TW_A-1:0] times_b(input int t3, input int t2, input int t1, input int t0);
        logic [NP*TW_A-1:0] r;
        r = '0;
        r[NP*TW_B-1:0] = {TW_B'(t3), TW_B'(t2), TW_B'(t1), TW_B'(t0)};
        return r;
    endfunction

    function automatic logic [NP*RW-1:0] ranks(input int r3, input int r2, input int r1, input int r0);
        return {RW'(r3), RW'(r2), RW'(r1), RW'(r0)};
    endfunction

    function automatic exp_t mk(input string n, input logic [NP-1:0] p, input logic [NP-1:0] c,
                                input logic [NP-1:0] d, input logic [NP*TW_A-1:0] t,
                                input logic [NP*RW-1:0] r);
        exp_t e;
        e.name = n; e.pressed = p; e.correct = c; e.disq = d; e.times = t; e.ranks = r;
        return e;
    endfunction

    // Monitor for the wide-counter instance: compare on every rising round_done
    always @(negedge clock) begin
        exp_t e;
        if (ifa.round_done && !done_a_prev) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL a_unexpected_done actual=1 expected=0");
            end else begin
                e = qa.pop_front();
                check_output({e.name, "_pressed"}, ifa.pressed, e.pressed);
                check_output({e.name, "_correct"}, ifa.correct, e.correct);
                check_output({e.name, "_disq"}, ifa.disq, e.disq);
                check_output({e.name, "_time"}, ifa.player_time, e.times);
                check_output({e.name, "_rank"}, ifa.player_rank, e.ranks);
            end
        end
        done_a_prev = ifa.round_done;
    end

    always @(negedge clock) begin
        exp_t e;
        if (ifb.round_done && !done_b_prev) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_unexpected_done actual=1 expected=0");
            end else begin
                e = qb.pop_front();
                check_output({e.name, "_pressed"}, ifb.pressed, e.pressed);
                check_output({e.name, "_correct"}, ifb.correct, e.correct);
                check_output({e.name, "_time"}, ifb.player_time, e.times);
                check_output({e.name, "_rank"}, ifb.player_rank, e.ranks);
            end
        end
        done_b_prev = ifb.round_done;
    end

    task automatic apply_stimulus(input logic st, input logic go, input logic t, input logic [NP-1:0] bz_low);
        ifa.start     = st;
        ifa.game_over = go;
        ifa.tic       = t;
        ifa.buzz_n    = ~bz_low;
        @(posedge clock); #1;
        ifa.start     = 1'b0;
        ifa.game_over = 1'b0;
        ifa.tic       = 1'b0;
        ifa.buzz_n    = '1;
    endtask

    task automatic start_a(input logic [2:0] qsel);
        ifa.question_sel = qsel;
        apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic tick_a(input int n);
        repeat (n) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, '0);
            apply_stimulus(1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic tick_b(input int n);
        repeat (n) begin
            ifb.tic = 1'b1;
            @(posedge clock); #1;
            ifb.tic = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic key_write(input logic [2:0] addr, input logic [3:0] data);
        ifa.key_we   = 1'b1;
        ifa.key_addr = addr;
        ifa.key_data = data;
        @(posedge clock); #1;
        ifa.key_we   = 1'b0;
    endtask

    initial begin
        ifa.tic = 0; ifa.start = 0; ifa.game_over = 0; ifa.question_sel = '0;
        ifa.buzz_n = '1; ifa.answer = '0; ifa.key_we = 0; ifa.key_addr = '0; ifa.key_data = '0;
        ifb.tic = 0; ifb.start = 0; ifb.game_over = 0; ifb.question_sel = '0;
        ifb.buzz_n = '1; ifb.answer = '0; ifb.key_we = 0; ifb.key_addr = '0; ifb.key_data = '0;

        repeat (2) @(posedge clock);
        #1;
        check_output("reset_armed", ifa.armed, 0);
        check_output("reset_done", ifa.round_done, 0);
        check_output("reset_pressed", ifa.pressed, 0);
        check_output("reset_rank", ifa.player_rank, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Round 1: ordered buzzes with a tie, default key[2] = 0100
        qa.push_back(mk("r1", 4'b1111, 4'b1011, 4'b0000, times_a(12, 9, 9, 5), ranks(3, 2, 2, 1)));
        ifa.answer = {4'b0100, 4'b0010, 4'b0100, 4'b0100};
        start_a(3'd2);
        check_output("r1_armed", ifa.armed, 1);
        tick_a(5);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        check_output("r1_latency_pressed", ifa.pressed, 4'b0001);
        tick_a(4);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0110);
        tick_a(3);
        check_output("r1_not_done_yet", ifa.round_done, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1000);
        check_output("r1_done_after_last", ifa.round_done, 1);

        // Round 2: programmed key, rewritten mid-round without effect
        key_write(3'd5, 4'b1000);
        qa.push_back(mk("r2", 4'b1111, 4'b0010, 4'b0000, times_a(2, 2, 2, 2), ranks(1, 1, 1, 1)));
        ifa.answer = {4'b0001, 4'b0001, 4'b1000, 4'b0001};
        start_a(3'd5);
        key_write(3'd5, 4'b0001);
        tick_a(2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1111);

        // Round 3: timeout at 20 tics with a single buzzer
        qa.push_back(mk("r3", 4'b0100, 4'b0100, 4'b0000, times_a(20, 7, 20, 20), ranks(0, 1, 0, 0)));
        ifa.answer = {4'b0100, 4'b0100, 4'b0100, 4'b0100};
        start_a(3'd2);
        tick_a(7);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0100);
        tick_a(12);
        check_output("r3_open_at_19", ifa.round_done, 0);
        tick_a(1);
        check_output("r3_done_at_20", ifa.round_done, 1);

        // game_over beats start mid-round
        start_a(3'd2);
        tick_a(3);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        apply_stimulus(1'b1, 1'b1, 1'b0, '0);
        check_output("go_armed", ifa.armed, 0);
        check_output("go_done", ifa.round_done, 0);
        check_output("go_pressed", ifa.pressed, 0);
        check_output("go_correct", ifa.correct, 0);
        check_output("go_time", ifa.player_time, 0);
        check_output("go_rank", ifa.player_rank, 0);

        // Asynchronous reset mid-round, checked between clock edges
        start_a(3'd2);
        tick_a(2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0010);
        check_output("pre_reset_pressed", ifa.pressed, 4'b0010);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("async_reset_armed", ifa.armed, 0);
        check_output("async_reset_pressed", ifa.pressed, 0);
        check_output("async_reset_time", ifa.player_time, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Player 0 held low through start
`ifdef QUIZ_FALSE_START_EN
        qa.push_back(mk("r5", 4'b1111, 4'b1010, 4'b0001, times_a(3, 3, 2, 0), ranks(2, 2, 1, 0)));
`else
        qa.push_back(mk("r5", 4'b1111, 4'b1011, 4'b0000, times_a(3, 3, 2, 0), ranks(3, 3, 2, 1)));
`endif
        ifa.answer = {4'b0100, 4'b0001, 4'b0100, 4'b0100};
        ifa.question_sel = 3'd2;
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0001);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        tick_a(2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0010);
        tick_a(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1100);

        // Narrow counter: closes at 14 and never wraps
        qb.push_back(mk("r6", 4'b0000, 4'b0000, 4'b0000, times_b(14, 14, 14, 14), ranks(0, 0, 0, 0)));
        ifb.start = 1'b1;
        @(posedge clock); #1;
        ifb.start = 1'b0;
        tick_b(13);
        check_output("r6_open_at_13", ifb.round_done, 0);
        tick_b(7);
        check_output("r6_done", ifb.round_done, 1);

        repeat (3) @(posedge clock);
        #1;
        check_output("sb_a_drained", qa.size(), 0);
        check_output("sb_b_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
